// File: rtl/param_dram.sv
// Single-port 32-bit data RAM with an arithmetic-series preload, byte-lane writes and an illegal-access pulse.
// Optional fixed request stall is compiled in with `define PARAM_DRAM_STALL_EN.
module param_dram #(
  parameter int          ADDR_WIDTH  = 12,
  parameter int          INIT_COUNT  = 15,
  parameter logic [31:0] INIT_BASE   = 32'h12345678,
  parameter logic [31:0] INIT_STEP   = 32'hdcba1234,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        err
);

  // Handshake: a request (read or write) stays asserted with stable fields while
  // waitrequest is high; it is taken on the first rising edge where waitrequest is low.

  localparam int DEPTH   = 2 ** ADDR_WIDTH;
  localparam int PRE_N   = (INIT_COUNT < DEPTH) ? INIT_COUNT : DEPTH;
  localparam int DIRTY_W = (PRE_N > 0) ? PRE_N : 1;

  typedef enum logic [1:0] {IDLE, STALL, ACCEPT} state_t;

  state_t                  state;
  logic                    req;
  logic                    accept;
  logic                    oob;
  logic                    both;
  logic [ADDR_WIDTH-1:0]   idx;
  logic                    unused_lsb;

  assign req        = read | write;
  assign both       = read & write;
  assign idx        = address[ADDR_WIDTH+1:2];
  assign oob        = |address[31:ADDR_WIDTH+2];
  assign unused_lsb = ^address[1:0];
  assign accept     = (state == ACCEPT) & ~reset;

`ifdef PARAM_DRAM_STALL_EN
  localparam int              CW     = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0]   WAIT_C = CW'(WAIT_CYCLES);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt_next;
  end

  // Dropping the request mid-stall falls into the default and clears the count.
  always_comb begin
    cnt_next    = '0;
    state       = IDLE;
    waitrequest = 1'b0;
    if (req) begin
      if (cnt < WAIT_C) begin
        state       = STALL;
        waitrequest = 1'b1;
        cnt_next    = cnt + 1'b1;
      end else begin
        state = ACCEPT;
      end
    end
  end
`else
  localparam int unused_wait = WAIT_CYCLES;

  always_comb begin
    state       = req ? ACCEPT : IDLE;
    waitrequest = 1'b0;
  end
`endif

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Preloaded words are served from the series until first written; a dirty bit per
  // preloaded entry switches that entry over to the RAM array.
  logic [DIRTY_W-1:0] dirty = '0;
  logic [31:0]        mem [DEPTH];
  logic               pre_hit;
  logic [31:0]        cur_word;
  logic [31:0]        merged;

  always_comb begin
    pre_hit = 1'b0;
    for (int i = 0; i < PRE_N; i++) begin
      if (idx == ADDR_WIDTH'(i) && !dirty[i]) pre_hit = 1'b1;
    end
    cur_word = pre_hit ? bswap(INIT_BASE + INIT_STEP * 32'(idx)) : mem[idx];
    merged   = cur_word;
    for (int n = 0; n < 4; n++) begin
      if (byteenable[n]) merged[8*n +: 8] = writedata[8*n +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (accept && write && !oob && (|byteenable)) begin
      mem[idx] <= merged;
      for (int i = 0; i < PRE_N; i++) begin
        if (idx == ADDR_WIDTH'(i)) dirty[i] <= 1'b1;
      end
    end
  end

  // A simultaneous read+write is served as the write only, so readdata holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
      err      <= 1'b0;
    end else begin
      err <= accept & (oob | both);
      if (accept && read && !write) readdata <= oob ? 32'h0 : cur_word;
    end
  end

endmodule

// File: tb/tb_param_dram.sv
// Directed bench for param_dram: scoreboarded reads/writes, lane merges, illegal accesses and reset.
module tb_param_dram;

  localparam int AW = 12;
`ifdef PARAM_DRAM_STALL_EN
  localparam int EXP_WAIT = 2;
`else
  localparam int EXP_WAIT = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic        err_q[$];
  logic [31:0] model [0:63];
  logic [31:0] last_rd;

  param_dram dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .byteenable(byteenable), .writedata(writedata), .waitrequest(waitrequest),
    .readdata(readdata), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // One full transfer: predict, drive, wait out the stall, then score result and the idle cycle after.
  task automatic xfer(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wd);
    int          waits;
    logic        oob;
    logic [31:0] e_rd;
    logic [31:0] e_err;
    oob = ((addr >> (AW + 2)) != 0);
    if (rd && !wr) e_rd = oob ? 32'h0 : model[addr[7:2]];
    else           e_rd = last_rd;
    if (wr && !oob) begin
      for (int n = 0; n < 4; n++) begin
        if (be[n]) model[addr[7:2]][8*n +: 8] = wd[8*n +: 8];
      end
    end
    exp_q.push_back(e_rd);
    err_q.push_back(oob || (rd && wr));
    last_rd = e_rd;

    @(negedge clk);
    address = addr; read = rd; write = wr; byteenable = be; writedata = wd;
    waits = 0;
    while (waitrequest === 1'b1 && waits < 16) begin
      @(negedge clk);
      waits++;
    end
    check("stall_len", 32'(waits), 32'(EXP_WAIT));
    @(posedge clk);
    #1;
    read = 1'b0; write = 1'b0;
    if (exp_q.size() > 0) check("readdata", readdata, exp_q.pop_front());
    if (err_q.size() > 0) begin
      e_err = {31'b0, err_q.pop_front()};
      check("err_pulse", {31'b0, err}, e_err);
    end
    @(posedge clk);
    #1;
    check("err_one_cycle", {31'b0, err}, 32'h0);
    check("rd_hold", readdata, last_rd);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) model[i] = (i < 15) ? bswap(32'h12345678 + 32'hdcba1234 * i) : 'x;
    last_rd = 32'h0;
    reset = 1'b1; address = '0; read = 1'b0; write = 1'b0; byteenable = '0; writedata = '0;
    #3;
    check("reset_readdata", readdata, 32'h0);
    check("reset_err", {31'b0, err}, 32'h0);
    check("reset_wait", {31'b0, waitrequest}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    xfer(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
    check("preload_0", readdata, 32'h78563412);
    xfer(1'b1, 1'b0, 32'h4, 4'h0, 32'h0);
    check("preload_1", readdata, 32'hAC68EEEE);
    for (int i = 2; i < 15; i++) xfer(1'b1, 1'b0, 32'(i * 4), 4'h0, 32'h0);

    xfer(1'b0, 1'b1, 32'h10, 4'b0010, 32'hAABBCCDD);
    xfer(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
    check("lane1_merge", readdata, 32'h489FCC85);

    xfer(1'b0, 1'b1, 32'h14, 4'b0000, 32'h5A5A5A5A);
    xfer(1'b1, 1'b0, 32'h14, 4'h0, 32'h0);

    for (int k = 0; k < 6; k++) begin
      int          a;
      logic [31:0] d;
      a = $urandom_range(16, 40);
      d = $urandom;
      xfer(1'b0, 1'b1, 32'(a * 4), 4'hF, d);
      xfer(1'b1, 1'b0, 32'(a * 4), 4'h0, 32'h0);
      a = $urandom_range(5, 14);
      xfer(1'b0, 1'b1, 32'(a * 4), 4'($urandom_range(1, 15)), $urandom);
      xfer(1'b1, 1'b0, 32'(a * 4), 4'h0, 32'h0);
    end

    xfer(1'b1, 1'b0, 32'h4000, 4'h0, 32'h0);
    xfer(1'b0, 1'b1, 32'h4000, 4'hF, 32'hDEADBEEF);
    xfer(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
    check("oob_no_alias", readdata, 32'h78563412);

    xfer(1'b1, 1'b1, 32'h8, 4'hF, 32'h01020304);
    xfer(1'b1, 1'b0, 32'h8, 4'h0, 32'h0);
    check("both_is_write", readdata, 32'h01020304);

    // Reset lands on a write that is still stalling (or not yet taken) and must drop it.
    xfer(1'b1, 1'b0, 32'h4, 4'h0, 32'h0);
    @(negedge clk);
    address = 32'h0; write = 1'b1; byteenable = 4'hF; writedata = 32'hFFFFFFFF;
`ifdef PARAM_DRAM_STALL_EN
    @(posedge clk);
    #2;
`endif
    reset = 1'b1;
    #1;
    check("async_rst_readdata", readdata, 32'h0);
    check("async_rst_err", {31'b0, err}, 32'h0);
    @(posedge clk);
    #1;
    write = 1'b0;
    reset = 1'b0;
    last_rd = 32'h0;
    xfer(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
    check("rst_mem_kept", readdata, 32'h78563412);
    xfer(1'b0, 1'b1, 32'h0, 4'b1100, 32'hFFFF0000);
    xfer(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
    check("rewrite_0", readdata, 32'hFFFF3412);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/param_dram.md
PARAM_DRAM -- requirements
Module: param_dram

Interface
REQ-001 Parameter ADDR_WIDTH, default 12: word-address width; depth DEPTH = 2**ADDR_WIDTH 32-bit words.
REQ-002 Parameter INIT_COUNT, default 15: number of words preloaded at time zero.
REQ-003 Parameter INIT_BASE, default 32'h12345678: first term of the preload arithmetic series.
REQ-004 Parameter INIT_STEP, default 32'hdcba1234: preload series difference.
REQ-005 Parameter WAIT_CYCLES, default 2: stall cycles inserted per transfer; only used when stalls are compiled in.
REQ-006 clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 address  input  32  byte address; bits [1:0] ignored; word index = address[ADDR_WIDTH+1:2].
REQ-009 read  input  1  read request, held until accepted.
REQ-010 write  input  1  write request, held until accepted.
REQ-011 byteenable  input  4  write lane enables; bit n selects writedata[8n+7:8n].
REQ-012 writedata  input  32  write data.
REQ-013 waitrequest  output  1  high = request not accepted this cycle.
REQ-014 readdata  output  32  registered read data.
REQ-015 err  output  1  one-cycle pulse flagging an illegal accepted transfer.

Function
REQ-016 Preload: entry i (0 <= i < INIT_COUNT) SHALL hold byte-swap(INIT_BASE + INIT_STEP*i), 32-bit wrap; other entries undefined.
REQ-017 A transfer SHALL be accepted on a rising edge where (read or write) is high and waitrequest is low.
REQ-018 Stall counter cnt (0..WAIT_CYCLES): states IDLE (cnt=0, no request), STALL (request, cnt<WAIT_CYCLES), ACCEPT (request, cnt=WAIT_CYCLES).
REQ-019 waitrequest SHALL be combinational: (read or write) and cnt < WAIT_CYCLES.
REQ-020 cnt SHALL increment each edge in STALL, return to 0 on acceptance, and clear to 0 if the request drops during STALL.
REQ-021 Accepted write SHALL update only lanes with byteenable set; byteenable 4'b0000 leaves memory unchanged.
REQ-022 Accepted read SHALL load readdata on the accepting edge; readdata valid from the next cycle and held until the next accepted read.
REQ-023 Out-of-range (address[31:ADDR_WIDTH+2] nonzero): write ignored, read loads 32'h0, err pulses the following cycle.
REQ-024 read and write both high: treated as write, readdata unchanged, err pulses the following cycle.
REQ-025 err SHALL be low in every cycle not covered by REQ-023/REQ-024.
REQ-026 Back-to-back transfers SHALL each incur the full WAIT_CYCLES stall.

Reset
REQ-027 reset high SHALL immediately force cnt=0, readdata=32'h0, err=0, regardless of clk.
REQ-028 Memory contents SHALL NOT be altered by reset; a transfer stalled when reset asserts is discarded and restarts from cnt=0.

Configuration
REQ-029 Macro PARAM_DRAM_STALL_EN defined: stall behaviour per REQ-018..REQ-020 with WAIT_CYCLES.
REQ-030 Macro PARAM_DRAM_STALL_EN undefined: waitrequest tied 0, cnt absent, every request accepted on its first edge; all other behaviour unchanged.

Verification
REQ-031 Defaults, stall off: read address 0x0 -> readdata 32'h78563412 next cycle; address 0x4 -> 32'hAC68EEEE.
REQ-032 Stall on, WAIT_CYCLES=2: read 0x0 held -> waitrequest high 2 cycles, low on 3rd, readdata 32'h78563412 the cycle after acceptance.
REQ-033 Write 0x10, byteenable 4'b0010, writedata 32'hAABBCCDD, then read 0x10 -> 32'h489FCC85.
REQ-034 Read 0x4000 (ADDR_WIDTH=12) -> readdata 32'h0, err high exactly one cycle; write 0x4000 -> no entry changed, err pulses.
REQ-035 Stall on: assert reset after one stall cycle of a write to 0x0 -> readdata 0, err 0, entry 0 still 32'h78563412; re-issued write sees full 2-cycle stall.
REQ-036 read and write both high to 0x8, byteenable 4'b1111, writedata 32'h01020304 -> err pulses, readdata unchanged, later read 0x8 -> 32'h01020304.
